// File: rtl/sigmoid_arbiter_if.sv
// Bundle of request, sigmoid-unit and response signals for sigmoid_arbiter.
//   master : requesters plus external sigmoid unit (drives operands, sig_y, rsp_ready)
//   slave  : the arbiter (drives req_ready, sig_x, rsp_valid, rsp_data, busy)
interface sigmoid_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       sig_x;
    logic [DATA_W-1:0]       sig_y;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ*DATA_W-1:0] rsp_data;
    logic [N_REQ-1:0]        rsp_ready;
    logic                    busy;

    modport master (
        output req_valid, req_data, sig_y, rsp_ready,
        input  req_ready, sig_x, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, sig_y, rsp_ready,
        output req_ready, sig_x, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one external combinational sigmoid unit among
// N_REQ requesters. One operation every two cycles: IDLE accepts an operand,
// EVAL presents it on sig_x and captures sig_y into the winner's result slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sigmoid_arbiter_if.slave (request / sigmoid / response signals)
module sigmoid_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    sigmoid_arbiter_if.slave bus
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_W-1:0]       op_reg;
    logic [ID_W-1:0]         id_reg;
    logic [ID_W-1:0]         last_grant;
    logic [N_REQ-1:0]        rsp_valid_q;
    logic [N_REQ*DATA_W-1:0] rsp_data_q;

    logic [N_REQ-1:0]        eligible;
    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W:0]           cand;
    logic                    accept;
    logic [N_REQ-1:0]        req_ready_int;
    logic [DATA_W-1:0]       sig_x_int;
    logic                    busy_int;

    // A requester with an unconsumed result may not start another operation.
    assign eligible = bus.req_valid & ~rsp_valid_q;

    // Round-robin search starting one past the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && eligible[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && grant_found;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = EVAL;
            EVAL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        req_ready_int = '0;
        sig_x_int     = '0;
        busy_int      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) req_ready_int[grant_idx] = 1'b1;
            end
            EVAL: begin
                sig_x_int = op_reg;
                busy_int  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= '0;
            id_reg     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            op_reg     <= bus.req_data[grant_idx*DATA_W +: DATA_W];
            id_reg     <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    // Result slots: written when leaving EVAL, cleared on consume. The slot
    // being written cannot be valid, so set and clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (state == EVAL && id_reg == ID_W'(i)) begin
                    rsp_valid_q[i]                 <= 1'b1;
                    rsp_data_q[i*DATA_W +: DATA_W] <= bus.sig_y;
                end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.sig_x     = sig_x_int;
    assign bus.busy      = busy_int;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
